// File: rtl/chan_mux_pkg.sv
// Shared types and default widths for the channel scan multiplexer.
package chan_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_CH  = 8;

endpackage

// File: rtl/chan_first_set.sv
// Lowest-set-bit finder: index of the lowest asserted mask bit plus a found flag.
module chan_first_set
  import chan_mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Descending walk so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel registered multiplexer: one beat per direct request, or one beat
// per enabled channel in ascending order in scan mode, over a valid/ready stream.
module chan_scan_mux
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N_CH  = DEF_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic                  start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int N_PAD = 1 << SEL_W;

  state_t                  state, state_nxt;
  logic [N_CH-1:0]         scan_mask;
  logic [N_CH-1:0]         fs_src, fs_rest;
  logic [SEL_W-1:0]        fs_idx;
  logic                    fs_found;
  logic                    idle_accept, is_direct, empty_scan, hs, final_hs, load_req;
  logic [SEL_W-1:0]        load_idx;
  logic                    load_last;
  logic [N_CH-1:0]         load_mask;
  logic [N_PAD*WIDTH-1:0]  d_pad;
  logic [WIDTH-1:0]        load_data;

  // First beat scans the live enable mask; later beats scan what remains.
  assign fs_src = (state == ST_IDLE) ? ch_en : scan_mask;

  chan_first_set #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_first_set (
    .mask  (fs_src),
    .idx   (fs_idx),
    .found (fs_found)
  );

  assign fs_rest     = fs_src & ~(N_CH'(1) << fs_idx);
  assign idle_accept = (state == ST_IDLE) && start;
  assign is_direct   = (state == ST_IDLE) && (mode == MODE_DIRECT);
  assign empty_scan  = idle_accept && (mode == MODE_SCAN) && !fs_found;
  assign hs          = (state == ST_EMIT) && out_ready;
  assign final_hs    = hs && out_last;
  assign load_req    = (idle_accept && !empty_scan) || (hs && !out_last);

  // Zero-padding to a power-of-two channel count makes out-of-range selects read zero.
  assign d_pad     = (N_PAD*WIDTH)'(d);
  assign load_idx  = is_direct ? sel : fs_idx;
  assign load_data = d_pad[int'(load_idx)*WIDTH +: WIDTH];
  assign load_last = is_direct ? 1'b1 : (fs_rest == '0);
  assign load_mask = is_direct ? '0 : fs_rest;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (idle_accept && !empty_scan) state_nxt = ST_EMIT;
      ST_EMIT: if (final_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_EMIT);
    busy      = (state != ST_IDLE);
  end

  // Beat register: loads on accept or on a non-final handshake, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      scan_mask <= '0;
      done      <= 1'b0;
    end else begin
      done <= empty_scan || final_hs;
      if (load_req) begin
        out_data  <= load_data;
        out_ch    <= load_idx;
        out_last  <= load_last;
        scan_mask <= load_mask;
      end
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: default 8x8 instance plus 6-channel and 3-channel/16-bit variants.
module tb_chan_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default instance: N_CH=8, WIDTH=8
  logic        mode, start, out_ready, out_valid, out_last, busy, done;
  logic [2:0]  sel, out_ch;
  logic [7:0]  ch_en, out_data;
  logic [63:0] d;

  chan_scan_mux #(.WIDTH(8), .N_CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .ch_en(ch_en), .d(d),
    .start(start), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy), .done(done)
  );

  // Six-channel instance for the out-of-range select
  logic        mode6, start6, rdy6, vld6, last6, busy6, done6;
  logic [2:0]  sel6, ch6;
  logic [5:0]  ch_en6;
  logic [7:0]  data6;
  logic [47:0] d6;

  chan_scan_mux #(.WIDTH(8), .N_CH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .ch_en(ch_en6), .d(d6),
    .start(start6), .out_valid(vld6), .out_ready(rdy6), .out_data(data6),
    .out_ch(ch6), .out_last(last6), .busy(busy6), .done(done6)
  );

  // Three-channel, 16-bit instance
  logic        mode3, start3, rdy3, vld3, last3, busy3, done3;
  logic [1:0]  sel3, ch3;
  logic [2:0]  ch_en3;
  logic [15:0] data3;
  logic [47:0] d3;

  chan_scan_mux #(.WIDTH(16), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .ch_en(ch_en3), .d(d3),
    .start(start3), .out_valid(vld3), .out_ready(rdy3), .out_data(data3),
    .out_ch(ch3), .out_last(last3), .busy(busy3), .done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic v, input logic [7:0] dat,
                      input logic [2:0] ch, input logic last);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".data"},  64'(out_data),  64'(dat));
    check({tag, ".ch"},    64'(out_ch),    64'(ch));
    check({tag, ".last"},  64'(out_last),  64'(last));
    check({tag, ".done"},  64'(done),      64'(1'b0));
  endtask

  initial begin
    int sc_ch [4] = '{0, 2, 5, 7};
    rst_n = 1'b0;
    mode = 1'b0; sel = '0; ch_en = '0; start = 1'b0; out_ready = 1'b1;
    mode6 = 1'b0; sel6 = '0; ch_en6 = '0; start6 = 1'b0; rdy6 = 1'b1;
    mode3 = 1'b0; sel3 = '0; ch_en3 = '0; start3 = 1'b0; rdy3 = 1'b1;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 6; i++) d6[i*8 +: 8] = 8'h30 + 8'(i);
    for (int i = 0; i < 3; i++) d3[i*16 +: 16] = 16'hC000 + 16'(i);

    // Reset state
    step(); step();
    check("rst.valid", 64'(out_valid), 0);
    check("rst.data",  64'(out_data),  0);
    check("rst.ch",    64'(out_ch),    0);
    check("rst.last",  64'(out_last),  0);
    check("rst.busy",  64'(busy),      0);
    check("rst.done",  64'(done),      0);
    rst_n = 1'b1;
    step();

    // Direct select of channel 5
    d[5*8 +: 8] = 8'hA5;
    mode = 1'b0; sel = 3'd5; start = 1'b1;
    step();
    start = 1'b0;
    beat("direct", 1'b1, 8'hA5, 3'd5, 1'b1);
    check("direct.busy", 64'(busy), 1);
    step();
    check("direct.done",    64'(done),      1);
    check("direct.vld_off", 64'(out_valid), 0);
    check("direct.idle",    64'(busy),      0);
    step();
    check("direct.done_pulse", 64'(done), 0);
    d[5*8 +: 8] = 8'h15;

    // Back-to-back scan of 0b1010_0101
    mode = 1'b1; ch_en = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat($sformatf("scan.b%0d", k), 1'b1, 8'h10 + 8'(sc_ch[k]), 3'(sc_ch[k]), k == 3);
      step();
    end
    check("scan.done",    64'(done),      1);
    check("scan.vld_off", 64'(out_valid), 0);
    step();

    // Backpressure on channel 2, with a start (and changed mode/sel) while busy
    mode = 1'b1; ch_en = 8'hA5; start = 1'b1;
    step();
    beat("bp.b0", 1'b1, 8'h10, 3'd0, 1'b0);
    mode = 1'b0; sel = 3'd3; ch_en = 8'hFF;
    step();
    beat("bp.b1", 1'b1, 8'h12, 3'd2, 1'b0);
    out_ready = 1'b0; d[2*8 +: 8] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      beat($sformatf("bp.hold%0d", k), 1'b1, 8'h12, 3'd2, 1'b0);
    end
    out_ready = 1'b1; start = 1'b0;
    step();
    beat("bp.b2", 1'b1, 8'h15, 3'd5, 1'b0);
    step();
    beat("bp.b3", 1'b1, 8'h17, 3'd7, 1'b1);
    step();
    check("bp.done", 64'(done), 1);
    step();
    check("bp.no_extra", 64'(out_valid), 0);
    check("bp.done_pulse", 64'(done), 0);
    d[2*8 +: 8] = 8'h12;

    // Empty scan
    mode = 1'b1; ch_en = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    check("empty.valid", 64'(out_valid), 0);
    check("empty.busy",  64'(busy),      0);
    check("empty.done",  64'(done),      1);
    step();
    check("empty.done_pulse", 64'(done), 0);

    // Reset in the middle of a scan
    mode = 1'b1; ch_en = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat("mid.b1", 1'b1, 8'h12, 3'd2, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid.valid", 64'(out_valid), 0);
    check("mid.data",  64'(out_data),  0);
    check("mid.ch",    64'(out_ch),    0);
    check("mid.last",  64'(out_last),  0);
    check("mid.busy",  64'(busy),      0);
    step();
    check("mid.no_done", 64'(done),      0);
    check("mid.idle",    64'(out_valid), 0);
    mode = 1'b0; sel = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    beat("post.direct", 1'b1, 8'h12, 3'd2, 1'b1);
    step();
    check("post.done", 64'(done), 1);

    // Six channels: out-of-range select reads zero, in-range reads data
    mode6 = 1'b0; sel6 = 3'd7; start6 = 1'b1;
    step();
    start6 = 1'b0;
    check("n6.oor.valid", 64'(vld6),  1);
    check("n6.oor.data",  64'(data6), 0);
    check("n6.oor.ch",    64'(ch6),   7);
    check("n6.oor.last",  64'(last6), 1);
    step();
    check("n6.oor.done",  64'(done6), 1);
    check("n6.oor.busy",  64'(busy6), 0);
    sel6 = 3'd4; start6 = 1'b1;
    step();
    start6 = 1'b0;
    check("n6.sel4.data", 64'(data6), 64'h34);
    check("n6.sel4.ch",   64'(ch6),   4);
    step();

    // Three channels, 16-bit: full scan
    mode3 = 1'b1; ch_en3 = 3'b111; start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("n3.b%0d.valid", k), 64'(vld3),  1);
      check($sformatf("n3.b%0d.data", k),  64'(data3), 64'hC000 + 64'(k));
      check($sformatf("n3.b%0d.ch", k),    64'(ch3),   64'(k));
      check($sformatf("n3.b%0d.last", k),  64'(last3), 64'(k == 2));
      step();
    end
    check("n3.done",    64'(done3), 1);
    check("n3.vld_off", 64'(vld3),  0);
    check("n3.busy",    64'(busy3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
